// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle 32-bit shifter (SLL/SRL/SRA/ROR).
// Applies one log-shifter stage (1, 2, 4, 8, 16) per cycle, so latency is fixed for every shift amount.
module alu_shift_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] result_o,
    output logic        busy_o
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] LAST_STAGE = CW'(SW - 1);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e          state;
    state_e          state_nxt;
    logic [DW-1:0]   work;
    logic [DW-1:0]   work_shf;
    logic [2*DW-1:0] ext;
    logic [1:0]      op_q;
    logic [SW-1:0]   shamt_q;
    logic            sign_q;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   stage_amt;
    logic            accept;
    logic            req_ready_d;
    logic            rsp_valid_d;
    logic            busy_d;
    logic            b_unused;

    // Only the low five bits of the shift amount matter.
    assign b_unused = ^b_i[DW-1:SW];

    assign accept   = (state == ST_IDLE) && req_valid_i && !flush_i;
    assign result_o = work;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides any handshake or stage advance.
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
                ST_SHIFT: if (cnt == LAST_STAGE) state_nxt = ST_DONE;
                ST_DONE:  if (rsp_ready_i) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state, so the flops below track the state exactly.
    always_comb begin
        req_ready_d = (state_nxt == ST_IDLE);
        rsp_valid_d = (state_nxt == ST_DONE);
        busy_d      = (state_nxt != ST_IDLE);
    end

    // Registered handshake/status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            req_ready_o <= req_ready_d;
            rsp_valid_o <= rsp_valid_d;
            busy_o      <= busy_d;
        end
    end

    // One shifter stage of width 2^cnt for the latched operation.
    always_comb begin
        stage_amt = SW'(1) << cnt;
        ext       = '0;
        work_shf  = work;
        unique case (op_q)
            OP_SLL: work_shf = work << stage_amt;
            OP_SRL: work_shf = work >> stage_amt;
            OP_SRA: begin
                ext      = {{DW{sign_q}}, work} >> stage_amt;
                work_shf = ext[DW-1:0];
            end
            default: begin
                ext      = {work, work} >> stage_amt;
                work_shf = ext[DW-1:0];
            end
        endcase
    end

    // Datapath: latch the request on accept, then step through the five stages.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work    <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            sign_q  <= 1'b0;
            cnt     <= '0;
        end else if (flush_i) begin
            cnt <= '0;
        end else if (accept) begin
            work    <= a_i;
            op_q    <= op_i;
            shamt_q <= b_i[SW-1:0];
            sign_q  <= a_i[DW-1];
            cnt     <= '0;
        end else if (state == ST_SHIFT) begin
            if (shamt_q[cnt]) begin
                work <= work_shf;
            end
            if (cnt != LAST_STAGE) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq with an expected-result queue.
module tb_alu_shift_seq;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    always #5 clk = ~clk;

    alu_shift_seq dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .result_o    (result_o),
        .busy_o      (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [4:0] sh);
        case (op)
            SLL:     return a << sh;
            SRL:     return a >> sh;
            SRA:     return 32'($signed(a) >>> sh);
            default: return (a >> sh) | (a << (6'd32 - 6'(sh)));
        endcase
    endfunction

    task automatic check_reset_state();
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_result",    result_o,         32'h0);
    endtask

    // Drive one request; returns after the accept edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!req_ready_o && n < 20) begin
            step();
            n++;
        end
        if (!req_ready_o) chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid_i = 1'b1;
        op_i = op;
        a_i  = a;
        b_i  = b;
        exp_q.push_back(ref_shift(op, a, b[4:0]));
        step();
        req_valid_i = 1'b0;
        op_i = 2'($urandom);
        a_i  = $urandom;
        b_i  = $urandom;
        chk("busy_after_accept", 32'(busy_o), 32'd1);
    endtask

    // Wait for the response, optionally backpressure for 'hold' cycles, then compare.
    task automatic collect(input string tag, input int hold);
        int lat = 0;
        logic [31:0] exp;
        while (!rsp_valid_o && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        if (!rsp_valid_o) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        exp = exp_q.pop_front();
        chk(tag, result_o, exp);
        if (hold > 0) begin
            rsp_ready_i = 1'b0;
            for (int i = 0; i < hold; i++) begin
                step();
                chk({tag, "_hold_valid"}, 32'(rsp_valid_o), 32'd1);
                chk({tag, "_hold_result"}, result_o, exp);
                chk({tag, "_hold_ready"}, 32'(req_ready_o), 32'd0);
            end
            rsp_ready_i = 1'b1;
        end
        step();
        chk({tag, "_idle_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_idle_valid"}, 32'(rsp_valid_o), 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        op_i        = 2'b00;
        a_i         = 32'h0;
        b_i         = 32'h0;
        step();
        step();
        check_reset_state();
        rst_i = 1'b0;
        step();

        send(SRL, 32'h8000_0000, 32'd31);
        collect("srl31", 0);
        send(SRA, 32'h8000_0000, 32'h0000_0024);
        collect("sra_b24", 0);
        send(SLL, 32'h0000_0001, 32'd0);
        collect("sll0", 0);
        send(ROR, 32'h0000_0001, 32'd1);
        collect("ror1", 0);
        send(ROR, 32'h1234_5678, 32'd16);
        collect("ror16", 0);

        send(SRA, 32'h8765_4321, 32'd7);
        collect("bp_sra7", 10);

        // flush together with a request in IDLE must not accept
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        step();
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        chk("flush_idle_ready", 32'(req_ready_o), 32'd1);
        chk("flush_idle_busy",  32'(busy_o),      32'd0);

        // flush at E3: request dropped, no response
        send(SRL, 32'hFFFF_0000, 32'd3);
        step();
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        void'(exp_q.pop_back());
        chk("flush_e3_ready", 32'(req_ready_o), 32'd1);
        chk("flush_e3_busy",  32'(busy_o),      32'd0);
        chk("flush_e3_valid", 32'(rsp_valid_o), 32'd0);
        send(SLL, 32'h0000_00FF, 32'd8);
        collect("after_flush", 0);

        // reset while holding a result in DONE
        send(ROR, 32'h0000_00A5, 32'd4);
        rsp_ready_i = 1'b0;
        begin
            int lat = 0;
            while (!rsp_valid_o && lat < 20) begin
                step();
                lat++;
            end
            chk("rst_done_latency", 32'(lat), 32'd5);
            if (exp_q.size() != 0) chk("rst_done_result", result_o, exp_q.pop_front());
        end
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        check_reset_state();

        for (int k = 0; k < 8; k++) begin
            send(2'($urandom_range(0, 3)), $urandom, $urandom);
            collect("rand", $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_shift_seq.md
# alu_shift_seq

Multi-cycle shift sequencer for the pipeline's execute stage. Accepts one shift request (SLL, SRL, SRA, ROR) through a valid/ready handshake. Applies the five log-shifter stages (1, 2, 4, 8, 16 bits) to a working register, one stage per cycle, selected by shamt bits 0..4. Returns the result through a second valid/ready handshake. Latency is fixed, independent of the shift amount, so hazard logic sees a deterministic stall. Replaces a full single-cycle barrel shifter where area or timing on the execute path matters.

## Interface
- No parameters; datapath width fixed at 32.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  pipeline flush; aborts any in-flight request.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request; high only in IDLE.
- op_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- a_i  input  32  operand to shift.
- b_i  input  32  shift amount; only b_i[4:0] used, b_i[31:5] ignored.
- rsp_valid_o  output  1  result_o holds a completed result.
- rsp_ready_i  input  1  consumer takes the result.
- result_o  output  32  shifted value; meaningful only while rsp_valid_o=1.
- busy_o  output  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
  - req_ready_o = (state==IDLE).
  - rsp_valid_o = (state==DONE).
  - busy_o = (state!=IDLE).
- IDLE: on req_valid_i & req_ready_o & !flush_i, latch the following and go to SHIFT:
  - a_i into the working register work.
  - op_i and b_i[4:0] into registers.
  - Sign bit a_i[31] into a sign register.
  - Stage counter cnt to 0.
- SHIFT: each edge, if shamt[cnt]=1, shift work by 2^cnt; else hold work. Shift behaviour by op:
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, fill with the latched sign bit.
  - ROR: rotate right; bits leaving bit 0 enter at bit 31.
- cnt increments 0..4. On the edge processing cnt==4, go to DONE; cnt does not wrap.
- DONE: result_o = work and is held stable while rsp_ready_i=0. On rsp_ready_i=1, go to IDLE at the next edge.
- No request is accepted in DONE, including the handshake cycle; back-to-back throughput is one request per 7 cycles.
- flush_i=1 in any state: go to IDLE at the next edge, discarding the request. No response is produced for the flushed request.
- Priority: rst_i > flush_i > handshake/state advance.
- Inputs op_i/a_i/b_i are sampled only on the accept edge; changes afterwards have no effect.

## Timing
- Reset (edge with rst_i=1) leaves the block in IDLE with:
  - req_ready_o=1, rsp_valid_o=0, busy_o=0.
  - result_o=0x0000_0000, cnt=0.
- Accept at edge E0. Stages 0..4 are applied at edges E1..E5.
- rsp_valid_o rises after E5, i.e. in the 6th cycle after the accept cycle. Fixed latency for every shamt, including shamt=0.
- With rsp_ready_i=1 already high, DONE lasts exactly one cycle. req_ready_o rises after E6.
- Backpressure: rsp_valid_o and result_o are held unchanged for any number of cycles.
- flush_i and req_valid_i high together in IDLE: no accept; req_ready_o stays high.
- flush_i in DONE together with rsp_ready_i: treated as flush. The result is dropped and the consumer must ignore it.
- rst_i mid-SHIFT or in DONE: next cycle is IDLE with the reset values above.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.

## Test plan
- After reset, check req_ready_o=1, rsp_valid_o=0, busy_o=0, result_o=0.
- SRL, a=0x8000_0000, b=31 -> result 0x0000_0001. rsp_valid_o first seen in the 6th cycle after accept.
- SRA, a=0x8000_0000, b=0x0000_0024: only b[4:0]=4 is used -> result 0xF800_0000. SLL, a=0x0000_0001, b=0 -> result 0x0000_0001, same 6-cycle latency.
- ROR, a=0x0000_0001, b=1 -> result 0x8000_0000. ROR, a=0x1234_5678, b=16 -> result 0x5678_1234.
- Hold rsp_ready_i=0 for 10 cycles in DONE: result_o and rsp_valid_o stay stable and req_ready_o stays 0. Deassert-then-assert: IDLE is reached one edge after rsp_ready_i=1.
- Flush and reset, three cases:
  - flush_i pulsed at E3 of a request -> IDLE next cycle, no rsp_valid_o.
  - rst_i pulsed in DONE -> reset values.
  - New request (SLL, a=0x0000_00FF, b=8) issued right after the flush -> result 0x0000_FF00.
